// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_ASSERT = 3'd0,
    ST_WAIT_LOCK    = 3'd1,
    ST_FILTER       = 3'd2,
    ST_RUN          = 3'd3,
    ST_DLY_GUARD    = 3'd4,
    ST_FAIL         = 3'd5
  } pll_state_t;

  localparam logic [1:0] RETRY_SAT = 2'd3;

  // Counter width able to hold the largest of the cycle-count parameters.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the sequencer clock domain.
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Metastability chain, cleared by the sequencer reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset/bypass/dynamic delay, qualifies lock with a filter and timeout/retry,
// and holds the downstream core in reset until lock is stable.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int          RESET_CYCLES = 16,
  parameter int          LOCK_FILTER  = 64,
  parameter int          LOCK_TIMEOUT = 65536,
  parameter int          MAX_RETRIES  = 3,
  parameter logic [7:0]  DELAY_INIT   = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PLL_LOCK,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic [7:0] PLL_DYNAMICDELAY,
  input  logic       DLY_REQ,
  input  logic [7:0] DLY_VAL,
  output logic       DLY_ACK,
  output logic       CORE_RESET,
  output logic       READY,
  output logic       FAIL,
  output logic [1:0] RETRY_CNT
);

  localparam int            CW       = cnt_width(RESET_CYCLES, LOCK_FILTER, LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] FLT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);

  pll_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_tmo;
  logic [1:0]    r_retry;
  logic          r_resetb;
  logic          r_bypass;
  logic [7:0]    r_delay;
  logic          r_ack;
  logic          r_core_rst;
  logic          r_ready;
  logic          r_fail;

  logic          w_lock_s;
  logic          w_retry_ok;

  pll_lock_sync u_sync (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_async (PLL_LOCK),
    .o_sync  (w_lock_s)
  );

  assign w_retry_ok = (int'(r_retry) < MAX_RETRIES);

  // Sequencer FSM with its shared cycle counter, timeout counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_RESET_ASSERT;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_retry    <= 2'd0;
      r_resetb   <= 1'b0;
      r_bypass   <= 1'b1;
      r_delay    <= DELAY_INIT;
      r_ack      <= 1'b0;
      r_core_rst <= 1'b1;
      r_ready    <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_RESET_ASSERT: begin
          if (r_cnt == RST_LAST) begin
            r_state  <= ST_WAIT_LOCK;
            r_resetb <= 1'b1;
            r_cnt    <= '0;
            r_tmo    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // Timeout has priority: an attempt never outlives its window, even mid-filter.
        ST_WAIT_LOCK, ST_FILTER: begin
          if (r_tmo == TMO_LAST) begin
            r_cnt      <= '0;
            r_resetb   <= 1'b0;
            r_bypass   <= 1'b1;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
            if (w_retry_ok) begin
              r_state <= ST_RESET_ASSERT;
              r_retry <= (r_retry == RETRY_SAT) ? r_retry : r_retry + 2'd1;
            end else begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end
          end else begin
            r_tmo <= r_tmo + CNT_ONE;
            if (r_state == ST_WAIT_LOCK) begin
              if (w_lock_s) begin
                r_state <= ST_FILTER;
                r_cnt   <= '0;
              end
            end else if (!w_lock_s) begin
              r_state <= ST_WAIT_LOCK;
            end else if (r_cnt == FLT_LAST) begin
              r_state    <= ST_RUN;
              r_bypass   <= 1'b0;
              r_core_rst <= 1'b0;
              r_ready    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end

        // Lock loss outranks a delay request arriving in the same cycle.
        ST_RUN: begin
          if (!w_lock_s) begin
            r_state    <= ST_RESET_ASSERT;
            r_cnt      <= '0;
            r_resetb   <= 1'b0;
            r_bypass   <= 1'b1;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
            r_retry    <= 2'd0;
          end else if (DLY_REQ) begin
            r_state    <= ST_DLY_GUARD;
            r_cnt      <= '0;
            r_ack      <= 1'b1;
            r_delay    <= DLY_VAL;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
          end
        end

        ST_DLY_GUARD: begin
          if (r_cnt == RST_LAST) begin
            r_state <= ST_FILTER;
            r_cnt   <= '0;
            r_tmo   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_FAIL: begin
          r_resetb   <= 1'b0;
          r_bypass   <= 1'b1;
          r_core_rst <= 1'b1;
          r_ready    <= 1'b0;
          r_fail     <= 1'b1;
        end

        default: begin
          r_state    <= ST_RESET_ASSERT;
          r_cnt      <= '0;
          r_resetb   <= 1'b0;
          r_bypass   <= 1'b1;
          r_core_rst <= 1'b1;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign PLL_RESETB       = r_resetb;
  assign PLL_BYPASS       = r_bypass;
  assign PLL_DYNAMICDELAY = r_delay;
  assign DLY_ACK          = r_ack;
  assign CORE_RESET       = r_core_rst;
  assign READY            = r_ready;
  assign FAIL             = r_fail;
  assign RETRY_CNT        = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed/randomised bench: expected outputs per cycle come from event times derived from the sequencing rules.
module tb_pll_lock_sequencer;

  localparam int RC  = 4;
  localparam int LF  = 8;
  localparam int LT  = 100;
  localparam int MR  = 2;
  localparam int LAT = 2 + LF + 1;   // PLL_LOCK rise to READY
  localparam int P   = RC + LT;      // one failed attempt

  logic       CLK;
  logic       RST;
  logic       PLL_LOCK;
  logic       PLL_RESETB;
  logic       PLL_BYPASS;
  logic [7:0] PLL_DYNAMICDELAY;
  logic       DLY_REQ;
  logic [7:0] DLY_VAL;
  logic       DLY_ACK;
  logic       CORE_RESET;
  logic       READY;
  logic       FAIL;
  logic [1:0] RETRY_CNT;

  int errors = 0;
  int checks = 0;
  int t = 0;

  int d, d2, r, f, tr, p, tl, tr3, ta, tr4, q, att;
  logic [7:0]  v;
  logic        rdy;
  logic [15:0] rst_vec;
  logic [15:0] fail_vec;

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_FILTER  (LF),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRIES  (MR),
    .DELAY_INIT   (8'h00)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .PLL_LOCK         (PLL_LOCK),
    .PLL_RESETB       (PLL_RESETB),
    .PLL_BYPASS       (PLL_BYPASS),
    .PLL_DYNAMICDELAY (PLL_DYNAMICDELAY),
    .DLY_REQ          (DLY_REQ),
    .DLY_VAL          (DLY_VAL),
    .DLY_ACK          (DLY_ACK),
    .CORE_RESET       (CORE_RESET),
    .READY            (READY),
    .FAIL             (FAIL),
    .RETRY_CNT        (RETRY_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] ev(input logic resetb, bypass, input logic [7:0] dly,
                                     input logic ack, core, ready, fl, input logic [1:0] retry);
    return {resetb, bypass, dly, ack, core, ready, fl, retry};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp_v);
    logic [15:0] obs_v;
    obs_v = {PLL_RESETB, PLL_BYPASS, PLL_DYNAMICDELAY, DLY_ACK, CORE_RESET, READY, FAIL, RETRY_CNT};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs_v, exp_v);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; PLL_LOCK = 1'b0; DLY_REQ = 1'b0; DLY_VAL = 8'h00;
    tick();
    tick();
    chk("reset", rst_vec);
    RST = 1'b0;
    t = 0;
  endtask

  // Lock rises d cycles after PLL_RESETB rises; check every cycle up to t_end.
  task automatic nominal_to(input int dd, input int t_end, input string tag);
    int trn;
    trn = RC + dd + LAT;
    while (t < t_end) begin
      PLL_LOCK = (t >= RC + dd);
      tick();
      chk(tag, ev(t >= RC, t < trn, 8'h00, 1'b0, t < trn, t >= trn, 1'b0, 2'd0));
    end
  endtask

  initial begin
    rst_vec  = ev(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    fail_vec = ev(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
    RST = 1'b1; PLL_LOCK = 1'b0; DLY_REQ = 1'b0; DLY_VAL = 8'h00;

    // 1. nominal lock, fixed then random lock delay
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 10 : int'($urandom_range(60, 1));
      do_reset();
      nominal_to(d, RC + d + LAT + 3, "nominal");
    end

    // 2. glitchy lock: g high, 1 low, then steady
    for (int i = 0; i < 3; i++) begin
      do_reset();
      d = int'($urandom_range(30, 1));
      f = int'($urandom_range(LF, 1));
      tr = RC + d + f + 1 + LAT;
      while (t < tr + 3) begin
        PLL_LOCK = ((t >= RC + d) && (t < RC + d + f)) || (t >= RC + d + f + 1);
        tick();
        chk("glitch", ev(t >= RC, t < tr, 8'h00, 1'b0, t < tr, t >= tr, 1'b0, 2'd0));
      end
    end

    // 3. timeout, retries, sticky FAIL
    do_reset();
    while (t < 3 * P + 6) begin
      tick();
      att = t / P;
      if (t >= 3 * P) chk("tmo_final", fail_vec);
      else chk("tmo", ev((t % P) >= RC, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'(att)));
    end
    PLL_LOCK = 1'b1; DLY_REQ = 1'b1; DLY_VAL = 8'hC3;
    repeat (20) begin
      tick();
      chk("fail_sticky", fail_vec);
    end

    // 4. delay change in RUN
    for (int i = 0; i < 2; i++) begin
      do_reset();
      d = int'($urandom_range(40, 1));
      r = int'($urandom_range(4, 0));
      v = (i == 0) ? 8'h5A : 8'($urandom_range(255, 1));
      tr = RC + d + LAT;
      q = tr + r;
      nominal_to(d, q, "dly_pre");
      DLY_VAL = v;
      ta = q + 1;
      tr2_loop: while (t < ta + RC + LF + 3) begin
        if (t == q) DLY_REQ = 1'b1;
        tick();
        rdy = (t >= ta + RC + LF);
        chk("dly", ev(1'b1, 1'b0, (t >= ta) ? v : 8'h00, t == ta, !rdy, rdy, 1'b0, 2'd0));
        if (DLY_ACK) DLY_REQ = 1'b0;
      end
    end

    // 5. one failed attempt, lock, then lock loss with a simultaneous delay request
    do_reset();
    d = int'($urandom_range(40, 1));
    d2 = int'($urandom_range(40, 1));
    r = int'($urandom_range(4, 1));
    v = 8'($urandom_range(255, 1));
    tr = P + RC + d + LAT;
    p = tr + r;
    tl = p + 3;
    tr3 = tl + RC + d2 + LAT;
    ta = tr3 + 1;
    tr4 = ta + RC + LF;
    DLY_VAL = v;
    while (t < tr4 + 3) begin
      PLL_LOCK = ((t >= P + RC + d) && (t < p)) || (t >= tl + RC + d2);
      if (t == p + 2) DLY_REQ = 1'b1;
      tick();
      rdy = ((t >= tr) && (t < tl)) || (t == tr3) || (t >= tr4);
      chk("loss", ev(!((t < RC) || ((t >= P) && (t < P + RC)) || ((t >= tl) && (t < tl + RC))),
                     !(((t >= tr) && (t < tl)) || (t >= tr3)),
                     (t >= ta) ? v : 8'h00, t == ta, !rdy, rdy, 1'b0,
                     ((t >= P) && (t < tl)) ? 2'd1 : 2'd0));
      if (DLY_ACK) DLY_REQ = 1'b0;
    end

    // 6a. RST mid-FILTER
    do_reset();
    d = int'($urandom_range(40, 1));
    f = int'($urandom_range(6, 1));
    nominal_to(d, RC + d + 2 + f, "pre_rst_filter");
    RST = 1'b1;
    tick();
    chk("rst_filter", rst_vec);
    RST = 1'b0;

    // 6b. RST mid-DLY_GUARD
    do_reset();
    d = int'($urandom_range(40, 1));
    tr = RC + d + LAT;
    nominal_to(d, tr, "pre_rst_guard");
    v = 8'($urandom_range(255, 1));
    DLY_VAL = v;
    DLY_REQ = 1'b1;
    tick();
    chk("guard_ack", ev(1'b1, 1'b0, v, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
    DLY_REQ = 1'b0;
    f = int'($urandom_range(2, 0));
    repeat (f) begin
      tick();
      chk("guard", ev(1'b1, 1'b0, v, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
    end
    RST = 1'b1;
    tick();
    chk("rst_guard", rst_vec);
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
